ysyx_23060203_clint: RTL and testbench
======================================

# ysyx_23060203_clint

AXI4 read-only responder for the core-local interruptor timer: holds a free-running 64-bit `mtime` and returns it over the read channel. It is the slave endpoint that the read crossbar's CLINT port drives. It decodes the low/high word from `araddr[2]`, so it works unchanged at both the SoC base (0x0200_BFF8/0x0200_BFFC) and the simulation base (0xA000_0048/0xA000_004C). Each accepted AR takes a snapshot of `mtime`, so every beat of one burst comes from the same 64-bit value.

## Interface
- `TICK_DIV`, 1: clock cycles per `mtime` increment. Must be ≥1.
- `MTIME_INIT`, 64'h0: `mtime` value loaded at reset. Exists for test only; production uses 0.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `read`  `ysyx_23060203_axi_if.in`  —  AR and R channels of the shared AXI interface. This block is the slave on it.
  - Inputs: `arvalid` 1, `araddr` 32, `arid` ID_W, `arlen` 8, `arsize` 3, `arburst` 2, `rready` 1.
  - Outputs: `arready` 1, `rvalid` 1, `rdata` 32, `rresp` 2, `rlast` 1, `rid` ID_W.
  - The write channels of the interface are not connected here.

## Operation
- **Counter**
  - Prescaler `pre` counts 0..TICK_DIV-1.
  - When `pre == TICK_DIV-1`: `pre` returns to 0 and `mtime` increments by 1.
  - `mtime` wraps from 2^64-1 to 0.
  - Counting never pauses for bus activity.
- **States** (one-hot enum): ST_IDLE, ST_RESP.
- **ST_IDLE**
  - `arready = 1`, `rvalid = 0`.
  - On `arvalid & arready`, latch:
    - `snap = mtime` (the value in the handshake cycle, before that cycle's increment),
    - `rid_q = arid`, `len_q = arlen`, `burst_q = arburst`,
    - `sel_q = araddr[2]`, `beat = 0`.
  - Then go to ST_RESP.
- **ST_RESP**
  - `arready = 0`, `rvalid = 1`.
  - `rdata = sel_q ? snap[63:32] : snap[31:0]`.
  - `rid = rid_q`, `rresp = 2'b00` (OKAY), `rlast = (beat == len_q)`.
  - On `rvalid & rready & !rlast`: `beat++`. `sel_q` toggles if `burst_q != FIXED`; it holds if `burst_q == FIXED`. INCR and WRAP behave the same here.
  - On `rvalid & rready & rlast`: go to ST_IDLE.
- **Decode and width rules**
  - Only `araddr[2]` is decoded. Other offsets alias and still return OKAY.
  - `arsize` is ignored; a full 32-bit word is always returned.
  - `arlen` up to 255 is legal. Beats alternate low/high words, all from the same snapshot.
- R outputs are registered and stay stable while `rvalid & !rready`.

## Timing
- **Reset values**
  - Outputs: `rvalid = 0`, `rlast = 0`, `rdata = 0`, `rresp = 0`, `rid = 0`, `arready = 1` (in the first cycle after reset deasserts).
  - Internal: `mtime = MTIME_INIT`, `pre = 0`, state = ST_IDLE.
- **Latency**
  - AR handshake in cycle N gives the first `rvalid` in cycle N+1.
  - Each later beat appears in the cycle after the previous R handshake. Sustained rate is one beat per cycle with `rready` held high.
- **Turnaround**
  - After the last-beat handshake in cycle M: `arready = 1` in M+1. The earliest next AR handshake is M+1.
  - AR is never accepted in the same cycle as an R handshake.
- **Reset during ST_RESP**
  - The burst is abandoned with no further beats.
  - Next cycle: `rvalid = 0` and all values are at reset.
- **Simultaneous increment and AR**: the snapshot takes the pre-increment value. `mtime` still increments in that cycle.

## Structure
- Shared package `ysyx_23060203_pkg` holds:
  - the `clint_state_t` enum,
  - AXI constants: RESP_OKAY = 2'b00, BURST_FIXED = 2'b00, BURST_INCR = 2'b01,
  - CLINT_SEL_BIT = 2,
  - the ID_W parameter used by the interface.
- Sub-module `ysyx_23060203_mtime_counter`:
  - Parameters: TICK_DIV, MTIME_INIT.
  - Ports: clock, reset, and a 64-bit `mtime` output.
  - Contents: prescaler and 64-bit counter.
- The top level contains the FSM, snapshot, beat counter and R-channel registers.

## Test plan
- **Single low-word read.** TICK_DIV=1, MTIME_INIT=0. AR at cycle 10 with araddr=0xA000_0048, arlen=0, arid=3. Required: cycle 11 `rvalid=1`, `rdata` = `mtime` at cycle 10, `rlast=1`, `rid=3`, `rresp=0`; cycle 12 `arready=1`.
- **Coherent 2-beat burst.** MTIME_INIT=64'h0000_0000_FFFF_FFFE. AR INCR with arlen=1, araddr=0x0200_BFF8 at the cycle where `mtime=..._FFFF_FFFF`. Required: beat 0 `rdata=0xFFFF_FFFF` with `rlast=0`; beat 1 `rdata=0x0000_0000` with `rlast=1`. The high word must not read 1.
- **Backpressure.** `rready=0` for 5 cycles after `rvalid` rises. Required: `rvalid`, `rdata`, `rid` and `rlast` stay constant; `arready` stays 0; the handshake completes on the first cycle with `rready=1`.
- **FIXED burst.** FIXED, arlen=3, araddr=0xA000_004C. Required: 4 beats, all equal to `snap[63:32]`; `rlast` only on beat 3.
- **Reset mid-burst.** Reset asserted on beat 1 of an arlen=3 burst. Required: next cycle `rvalid=0`, `mtime=MTIME_INIT`; after reset deasserts, `arready=1`.
- **Prescaler.** TICK_DIV=4. Back-to-back low reads spaced 8 cycles apart. Required: returned values differ by exactly 2.

Source files
------------

// File: rtl/ysyx_23060203_pkg.sv
// ysyx_23060203_pkg: shared AXI constants, CLINT state encoding and word-select helper.
package ysyx_23060203_pkg;
  localparam int ID_W = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam int CLINT_SEL_BIT = 2;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b01,
    ST_RESP = 2'b10
  } clint_state_t;
  function automatic logic [31:0] word_of(input logic [63:0] v, input logic hi);
    return hi ? v[63:32] : v[31:0];
  endfunction
endpackage

// File: rtl/ysyx_23060203_axi_if.sv
// ysyx_23060203_axi_if: shared AXI4 bundle; the CLINT only uses the AR/R side through modport in.
interface ysyx_23060203_axi_if #(parameter int ID_W = ysyx_23060203_pkg::ID_W);
  logic            arvalid;
  logic            arready;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            rvalid;
  logic            rready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic [ID_W-1:0] rid;
  logic            awvalid;
  logic            awready;
  logic [31:0]     awaddr;
  logic            wvalid;
  logic            wready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  modport in (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
  modport out (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/ysyx_23060203_mtime_counter.sv
// ysyx_23060203_mtime_counter: prescaled free-running 64-bit mtime.
module ysyx_23060203_mtime_counter #(
  parameter int          TICK_DIV   = 1,
  parameter logic [63:0] MTIME_INIT = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] o_mtime
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  logic [PW-1:0] r_pre;
  logic [63:0]   r_mtime;
  logic          w_tick;
  assign w_tick = r_pre == PRE_MAX;
  assign o_mtime = r_mtime;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pre   <= '0;
      r_mtime <= MTIME_INIT;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_mtime <= r_mtime + 64'd1;
    end
  end
endmodule

// File: rtl/ysyx_23060203_clint.sv
// ysyx_23060203_clint: read-only AXI4 slave returning a per-burst snapshot of mtime.
module ysyx_23060203_clint
  import ysyx_23060203_pkg::*;
#(
  parameter int          TICK_DIV   = 1,
  parameter logic [63:0] MTIME_INIT = 64'h0
) (
  input logic              clock,
  input logic              reset,
  ysyx_23060203_axi_if.in  read
);
  logic [63:0]     w_mtime;
  logic            w_next_sel;
  clint_state_t    r_state;
  logic [63:0]     r_snap;
  logic [7:0]      r_len;
  logic [7:0]      r_beat;
  logic [1:0]      r_burst;
  logic            r_sel;
  logic            r_arready;
  logic            r_rvalid;
  logic            r_rlast;
  logic [31:0]     r_rdata;
  logic [ID_W-1:0] r_rid;
  ysyx_23060203_mtime_counter #(
    .TICK_DIV  (TICK_DIV),
    .MTIME_INIT(MTIME_INIT)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .o_mtime(w_mtime)
  );
  assign w_next_sel = (r_burst == BURST_FIXED) ? r_sel : ~r_sel;
  assign read.arready = r_arready;
  assign read.rvalid  = r_rvalid;
  assign read.rdata   = r_rdata;
  assign read.rresp   = RESP_OKAY;
  assign read.rlast   = r_rlast;
  assign read.rid     = r_rid;
  // R outputs are precomputed one cycle ahead so they come straight from flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_snap    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_burst   <= '0;
      r_sel     <= 1'b0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rid     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (read.arvalid) begin
          r_state   <= ST_RESP;
          r_snap    <= w_mtime;
          r_len     <= read.arlen;
          r_beat    <= '0;
          r_burst   <= read.arburst;
          r_sel     <= read.araddr[CLINT_SEL_BIT];
          r_arready <= 1'b0;
          r_rvalid  <= 1'b1;
          r_rlast   <= read.arlen == 8'd0;
          r_rdata   <= word_of(w_mtime, read.araddr[CLINT_SEL_BIT]);
          r_rid     <= read.arid;
        end
        ST_RESP: if (read.rready) begin
          if (r_rlast) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
          end else begin
            r_beat  <= r_beat + 8'd1;
            r_sel   <= w_next_sel;
            r_rlast <= r_beat + 8'd1 == r_len;
            r_rdata <= word_of(r_snap, w_next_sel);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_arready <= 1'b1;
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060203_clint.sv
// tb_ysyx_23060203_clint: directed checks on three CLINT configurations sharing clock and reset.
module tb_ysyx_23060203_clint;
  import ysyx_23060203_pkg::*;
  localparam int          DIV [3] = '{1, 1, 4};
  localparam logic [63:0] INIT[3] = '{64'h0, 64'h0000_0000_FFFF_FFFE, 64'h0};
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0] arvalid = '0;
  logic [2:0] rready = '0;
  logic [31:0] araddr[3];
  logic [7:0] arlen[3];
  logic [1:0] arburst[3];
  logic [ID_W-1:0] arid[3];
  logic [2:0] arready, rvalid, rlast;
  logic [31:0] rdata[3];
  logic [1:0] rresp[3];
  logic [ID_W-1:0] rid[3];
  logic [63:0] t = '0;
  int n_chk = 0;
  int n_err = 0;
  always #5 clock = ~clock;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_23060203_axi_if ax ();
    assign ax.arvalid = arvalid[g];
    assign ax.araddr  = araddr[g];
    assign ax.arid    = arid[g];
    assign ax.arlen   = arlen[g];
    assign ax.arsize  = 3'd2;
    assign ax.arburst = arburst[g];
    assign ax.rready  = rready[g];
    assign arready[g] = ax.arready;
    assign rvalid[g]  = ax.rvalid;
    assign rdata[g]   = ax.rdata;
    assign rresp[g]   = ax.rresp;
    assign rlast[g]   = ax.rlast;
    assign rid[g]     = ax.rid;
    ysyx_23060203_clint #(.TICK_DIV(DIV[g]), .MTIME_INIT(INIT[g])) u_dut (
      .clock(clock),
      .reset(reset),
      .read (ax.in)
    );
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // t mirrors the number of non-reset edges since the last reset edge.
  task automatic step();
    @(posedge clock);
    if (reset) t = '0;
    else t++;
    #1;
  endtask
  task automatic ar(input int i, input logic [31:0] a, input logic [7:0] l, input logic [1:0] b,
                    input logic [ID_W-1:0] id);
    chk("ar_ready", 64'(arready[i]), 64'd1);
    arvalid[i] = 1'b1;
    araddr[i] = a;
    arlen[i] = l;
    arburst[i] = b;
    arid[i] = id;
    step();
    arvalid[i] = 1'b0;
  endtask
  task automatic beat(input int i, input logic [31:0] d, input logic l, input logic [ID_W-1:0] id);
    chk("r_valid", 64'(rvalid[i]), 64'd1);
    chk("r_data", 64'(rdata[i]), 64'(d));
    chk("r_last", 64'(rlast[i]), 64'(l));
    chk("r_id", 64'(rid[i]), 64'(id));
    chk("r_resp", 64'(rresp[i]), 64'(RESP_OKAY));
    chk("ar_busy", 64'(arready[i]), 64'd0);
    rready[i] = 1'b1;
    step();
    rready[i] = 1'b0;
  endtask
  initial begin
    logic [63:0] e, ta;
    logic [31:0] d0, d1;
    for (int i = 0; i < 3; i++) begin
      araddr[i] = '0;
      arlen[i] = '0;
      arburst[i] = BURST_INCR;
      arid[i] = '0;
    end
    repeat (2) step();
    for (int i = 0; i < 3; i++) begin
      chk("rst_rvalid", 64'(rvalid[i]), 64'd0);
      chk("rst_rlast", 64'(rlast[i]), 64'd0);
      chk("rst_rdata", 64'(rdata[i]), 64'd0);
      chk("rst_rid", 64'(rid[i]), 64'd0);
      chk("rst_arready", 64'(arready[i]), 64'd1);
    end
    reset = 1'b0;
    step();
    ar(1, 32'h0200_BFF8, 8'd1, BURST_INCR, 4'd2);
    beat(1, 32'hFFFF_FFFF, 1'b0, 4'd2);
    beat(1, 32'h0000_0000, 1'b1, 4'd2);
    chk("coh_turn", 64'(arready[1]), 64'd1);
    while (t < 64'd10) step();
    e = t;
    ar(0, 32'hA000_0048, 8'd0, BURST_INCR, 4'd3);
    beat(0, e[31:0], 1'b1, 4'd3);
    chk("single_turn", 64'(arready[0]), 64'd1);
    chk("single_idle", 64'(rvalid[0]), 64'd0);
    e = INIT[1] + t;
    ar(1, 32'hA000_004C, 8'd1, BURST_INCR, 4'd5);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rvalid", 64'(rvalid[1]), 64'd1);
      chk("bp_rdata", 64'(rdata[1]), 64'(e[63:32]));
      chk("bp_rid", 64'(rid[1]), 64'd5);
      chk("bp_rlast", 64'(rlast[1]), 64'd0);
      chk("bp_arready", 64'(arready[1]), 64'd0);
      step();
    end
    beat(1, e[63:32], 1'b0, 4'd5);
    beat(1, e[31:0], 1'b1, 4'd5);
    e = INIT[1] + t;
    ar(1, 32'hA000_004C, 8'd3, BURST_FIXED, 4'd6);
    for (int k = 0; k < 4; k++) beat(1, e[63:32], k == 3, 4'd6);
    e = t;
    ar(0, 32'hA000_0048, 8'd3, BURST_INCR, 4'd7);
    beat(0, e[31:0], 1'b0, 4'd7);
    chk("mid_beat1", 64'(rvalid[0]), 64'd1);
    chk("mid_beat1_hi", 64'(rdata[0]), 64'(e[63:32]));
    reset = 1'b1;
    step();
    chk("mid_rvalid", 64'(rvalid[0]), 64'd0);
    chk("mid_rdata", 64'(rdata[0]), 64'd0);
    chk("mid_rlast", 64'(rlast[0]), 64'd0);
    chk("mid_rid", 64'(rid[0]), 64'd0);
    reset = 1'b0;
    chk("mid_arready", 64'(arready[0]), 64'd1);
    repeat (3) step();
    ar(0, 32'hA000_0048, 8'd0, BURST_INCR, 4'd1);
    beat(0, 32'd3, 1'b1, 4'd1);
    ta = t;
    ar(2, 32'hA000_0048, 8'd0, BURST_INCR, 4'd1);
    d0 = rdata[2];
    beat(2, 32'(ta / 4), 1'b1, 4'd1);
    while (t < ta + 64'd8) step();
    ar(2, 32'hA000_0048, 8'd0, BURST_INCR, 4'd1);
    d1 = rdata[2];
    beat(2, 32'((ta + 64'd8) / 4), 1'b1, 4'd1);
    chk("pre_diff", 64'(d1 - d0), 64'd2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
